// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: state encoding and default widths.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 6;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FORCE = 2'd1;
    localparam logic [1:0] ST_CAP   = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StForce = ST_FORCE,
        StCap   = ST_CAP,
        StAck   = ST_ACK
    } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, debug and memory-side signals around the data-memory arbiter.
interface dmem_port_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);

    logic              cpu_mem_req;
    logic              cpu_mem_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              stall_req;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view.
    modport slave (
        input  cpu_mem_req, cpu_mem_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_addr,
        input  mem_rdata,
        output cpu_rdata, dbg_ack, dbg_rdata, stall_req,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Surrounding pipeline, debug port and memory.
    modport master (
        output cpu_mem_req, cpu_mem_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_addr,
        output mem_rdata,
        input  cpu_rdata, dbg_ack, dbg_rdata, stall_req,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/arb_starve_cnt.sv
// Saturating count of IDLE cycles in which a pending debug read lost to the CPU.
module arb_starve_cnt #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_o
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STARVE_LIMIT - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CntLast)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign limit_o = (cnt_q == CntLast);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the synchronous-read data memory between the MEM stage (fixed priority) and the
// board debug read port, forcing a one-cycle pipeline stall when a debug read starves.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dmem_port_arbiter_if.slave        bus_io
);

    arb_state_e        state_q;
    logic              stall_q;
    logic              dbg_ack_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    logic              dbg_grant;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_limit;
    logic [ADDR_W-1:0] addr_mux;

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .limit_o (cnt_limit)
    );

    // Counter only advances while a debug read is blocked in IDLE; any other cycle clears it.
    always_comb begin
        cnt_clr = 1'b1;
        cnt_inc = 1'b0;
        if ((state_q == StIdle) && bus_io.dbg_req && bus_io.cpu_mem_req && !cnt_limit) begin
            cnt_clr = 1'b0;
            cnt_inc = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            stall_q     <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
        end else begin
            stall_q   <= 1'b0;
            dbg_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.dbg_req) begin
                        if (!bus_io.cpu_mem_req) begin
                            state_q <= StCap;
                        end else if (cnt_limit) begin
                            state_q <= StForce;
                            stall_q <= 1'b1;
                        end
                    end
                end
                StForce: begin
                    state_q <= StCap;
                end
                StCap: begin
                    dbg_rdata_q <= bus_io.mem_rdata;
                    dbg_ack_q   <= 1'b1;
                    state_q     <= StAck;
                end
                StAck: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dbg_grant = (state_q == StForce) ||
                       ((state_q == StIdle) && bus_io.dbg_req && !bus_io.cpu_mem_req);

    // Reset gates the enables so nothing reaches the memory while rst_n is held.
    always_comb begin
        bus_io.mem_en = 1'b0;
        bus_io.mem_we = 1'b0;
        addr_mux      = bus_io.cpu_addr;
        if (dbg_grant) begin
            addr_mux = bus_io.dbg_addr;
        end
        if (rst_n) begin
            if (dbg_grant) begin
                bus_io.mem_en = 1'b1;
            end else begin
                bus_io.mem_en = bus_io.cpu_mem_req;
                bus_io.mem_we = bus_io.cpu_mem_req & bus_io.cpu_mem_we;
            end
        end
    end

    assign bus_io.mem_addr  = addr_mux;
    assign bus_io.mem_wdata = bus_io.cpu_wdata;
    assign bus_io.cpu_rdata = bus_io.mem_rdata;
    assign bus_io.stall_req = stall_q;
    assign bus_io.dbg_ack   = dbg_ack_q;
    assign bus_io.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: per-cycle vector table plus reset corner cases.
module tb_dmem_port_arbiter;

    localparam int unsigned AW  = 6;
    localparam int unsigned DW  = 32;
    localparam int unsigned LIM = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    function automatic logic [31:0] init_word(input int a);
        logic [5:0] a6;
        a6 = 6'(a);
        return (a6 == 6'd5) ? 32'hDEADBEEF : {16'hC0DE, 10'd0, a6};
    endfunction

    // Synchronous-read single-port memory; preloads itself on the first clock.
    logic [DW-1:0] mem [64];
    logic          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    typedef struct {
        logic        cr, cw;
        logic [5:0]  ca;
        logic [31:0] cd;
        logic        dr;
        logic [5:0]  da;
        logic        en, we;
        logic [5:0]  ea;
        logic        st, ack, push, chk_cpu;
        logic [31:0] ecpu;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    logic [31:0] shadow[64];
    logic [31:0] last_rd;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    task automatic add(input int cr, input int cw, input int ca, input int cd, input int dr,
                       input int da, input int en, input int we, input int ea, input int st,
                       input int ack, input int push);
        vec_t v;
        v.cr = cr[0]; v.cw = cw[0]; v.ca = 6'(ca); v.cd = 32'(cd);
        v.dr = dr[0]; v.da = 6'(da);
        v.en = en[0]; v.we = we[0]; v.ea = 6'(ea);
        v.st = st[0]; v.ack = ack[0]; v.push = push[0];
        v.chk_cpu = 1'b0; v.ecpu = '0;
        vecs.push_back(v);
    endtask

    task automatic mark_cpu(input logic [31:0] e);
        vecs[vecs.size()-1].chk_cpu = 1'b1;
        vecs[vecs.size()-1].ecpu    = e;
    endtask

    task automatic drive(input int cr, input int cw, input int ca, input int cd, input int dr,
                         input int da);
        bus.cpu_mem_req = cr[0];
        bus.cpu_mem_we  = cw[0];
        bus.cpu_addr    = 6'(ca);
        bus.cpu_wdata   = 32'(cd);
        bus.dbg_req     = dr[0];
        bus.dbg_addr    = 6'(da);
    endtask

    task automatic run_table(input string tag);
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(posedge clk); #1;
            drive(int'(v.cr), int'(v.cw), int'(v.ca), int'(v.cd), int'(v.dr), int'(v.da));
            if (v.push) sb.push_back(shadow[v.da]);
            if (v.we) shadow[v.ea] = v.cd;
            @(negedge clk);
            check($sformatf("%s%0d mem_en", tag, i), 32'(bus.mem_en), 32'(v.en));
            check($sformatf("%s%0d mem_we", tag, i), 32'(bus.mem_we), 32'(v.we));
            check($sformatf("%s%0d mem_addr", tag, i), 32'(bus.mem_addr), 32'(v.ea));
            check($sformatf("%s%0d stall_req", tag, i), 32'(bus.stall_req), 32'(v.st));
            check($sformatf("%s%0d dbg_ack", tag, i), 32'(bus.dbg_ack), 32'(v.ack));
            if (v.we) check($sformatf("%s%0d mem_wdata", tag, i), bus.mem_wdata, v.cd);
            if (bus.dbg_ack === 1'b1) begin
                if (sb.size() == 0) check($sformatf("%s%0d ack_unexpected", tag, i), 32'd1, 32'd0);
                else last_rd = sb.pop_front();
            end
            check($sformatf("%s%0d dbg_rdata", tag, i), bus.dbg_rdata, last_rd);
            if (v.chk_cpu) check($sformatf("%s%0d cpu_rdata", tag, i), bus.cpu_rdata, v.ecpu);
        end
        vecs.delete();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        last_rd = '0;

        // Reset held with both requesters active.
        rst_n = 1'b0;
        drive(1, 1, 7, 32'h1111, 1, 5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst mem_en", 32'(bus.mem_en), 32'd0);
        check("rst mem_we", 32'(bus.mem_we), 32'd0);
        check("rst stall_req", 32'(bus.stall_req), 32'd0);
        check("rst dbg_ack", 32'(bus.dbg_ack), 32'd0);
        check("rst dbg_rdata", bus.dbg_rdata, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Idle-port read of word 5, then back-to-back read of word 9.
        add(0, 0, 0, 0, 1, 5,  1, 0, 5,  0, 0, 1);
        add(0, 0, 0, 0, 1, 5,  0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 5,  0, 0, 0,  0, 1, 0);
        add(0, 0, 0, 0, 1, 9,  1, 0, 9,  0, 0, 1);
        add(0, 0, 0, 0, 1, 9,  0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 9,  0, 0, 0,  0, 1, 0);
        add(1, 0, 2, 0, 0, 0,  1, 0, 2,  0, 0, 0);
        // Starvation: FORCE after LIM blocked cycles, CPU write held over FORCE.
        for (int i = 0; i < int'(LIM); i++) begin
            add(1, 0, 16 + i, 0, 1, 12,  1, 0, 16 + i,  0, 0, 0);
            if (i > 0) mark_cpu(init_word(16 + i - 1));
        end
        add(1, 1, 3, 32'h12345678, 1, 12,  1, 0, 12,  1, 0, 1);
        add(1, 1, 3, 32'h12345678, 1, 12,  1, 1, 3,   0, 0, 0);
        add(1, 0, 3, 0,            1, 12,  1, 0, 3,   0, 1, 0);
        add(0, 0, 0, 0,            0, 0,   0, 0, 0,   0, 0, 0);
        mark_cpu(32'h12345678);
        add(0, 0, 0, 0, 1, 3,  1, 0, 3,  0, 0, 1);
        add(0, 0, 0, 0, 1, 3,  0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 3,  0, 0, 0,  0, 1, 0);
        // Counter clear: 5 blocked cycles, a free cycle, then a fresh full wait.
        for (int i = 0; i < 5; i++) add(1, 0, 30 + i, 0, 1, 20,  1, 0, 30 + i,  0, 0, 0);
        add(0, 0, 0, 0, 1, 20,  1, 0, 20,  0, 0, 1);
        add(0, 0, 0, 0, 1, 20,  0, 0, 0,   0, 0, 0);
        add(0, 0, 0, 0, 1, 20,  0, 0, 0,   0, 1, 0);
        for (int i = 0; i < int'(LIM); i++) add(1, 0, 40 + i, 0, 1, 21,  1, 0, 40 + i,  0, 0, 0);
        add(1, 0, 50, 0, 1, 21,  1, 0, 21,  1, 0, 1);
        add(1, 0, 50, 0, 1, 21,  1, 0, 50,  0, 0, 0);
        add(0, 0, 0,  0, 1, 21,  0, 0, 0,   0, 1, 0);
        add(0, 0, 0,  0, 0, 0,   0, 0, 0,   0, 0, 0);
        run_table("v");

        // Reset in the middle of CAP.
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 1, 7);
        @(negedge clk);
        check("r1 grant mem_en", 32'(bus.mem_en), 32'd1);
        check("r1 grant mem_addr", 32'(bus.mem_addr), 32'd7);
        @(posedge clk); #1;
        drive(1, 0, 4, 0, 1, 7);
        #1 rst_n = 1'b0;
        #1;
        check("r1 dbg_ack", 32'(bus.dbg_ack), 32'd0);
        check("r1 dbg_rdata", bus.dbg_rdata, 32'd0);
        check("r1 stall_req", 32'(bus.stall_req), 32'd0);
        check("r1 mem_en", 32'(bus.mem_en), 32'd0);
        last_rd = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1, 0, 4, 0, 0, 0);
        @(negedge clk);
        check("r1 post mem_en", 32'(bus.mem_en), 32'd1);
        check("r1 post mem_addr", 32'(bus.mem_addr), 32'd4);
        check("r1 post dbg_ack", 32'(bus.dbg_ack), 32'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("r1 idle mem_en", 32'(bus.mem_en), 32'd0);
        check("r1 idle dbg_ack", 32'(bus.dbg_ack), 32'd0);

        // Reset in the middle of FORCE, with a CPU write presented.
        for (int i = 0; i < int'(LIM); i++) begin
            @(posedge clk); #1;
            drive(1, 0, 8, 0, 1, 9);
            @(negedge clk);
            check($sformatf("r2 blocked%0d stall_req", i), 32'(bus.stall_req), 32'd0);
        end
        @(posedge clk); #1;
        drive(1, 1, 3, 32'hFFFFFFFF, 1, 9);
        @(negedge clk);
        check("r2 force stall_req", 32'(bus.stall_req), 32'd1);
        check("r2 force mem_we", 32'(bus.mem_we), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("r2 rst stall_req", 32'(bus.stall_req), 32'd0);
        check("r2 rst mem_en", 32'(bus.mem_en), 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        add(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 3,  1, 0, 3,  0, 0, 1);
        add(0, 0, 0, 0, 1, 3,  0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0, 1, 3,  0, 0, 0,  0, 1, 0);
        add(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0);
        run_table("p");

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
